// File: rtl/serial_deser_if.sv
// serial_deser_if
//   Bundles the serial input and word output handshake of serial_deser.
//   slave  : the deserializer side (samples bits, drives the word output)
//   master : the producer/consumer side (drives bits and ready_i)
//   Signals:
//     bit_i, bit_valid_i, frame_i : serial bit, qualifier, start-of-word marker
//     data_o, valid_o, ready_i    : assembled word with valid/ready handshake
//     overrun_o, frame_err_o      : one-cycle error pulses
interface serial_deser_if #(
    parameter int WIDTH = 8
);
    logic             bit_i;
    logic             bit_valid_i;
    logic             frame_i;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             overrun_o;
    logic             frame_err_o;

    modport slave (
        input  bit_i, bit_valid_i, frame_i, ready_i,
        output data_o, valid_o, overrun_o, frame_err_o
    );

    modport master (
        output bit_i, bit_valid_i, frame_i, ready_i,
        input  data_o, valid_o, overrun_o, frame_err_o
    );
endinterface

// File: rtl/serial_deser_hold.sv
// serial_deser_hold
//   One-word output holding register with valid/ready handshake.
//   A completed word is loaded when the register is free (empty, or being
//   consumed on the same edge); otherwise the word is dropped and overrun_o
//   pulses for one cycle.
//   Ports:
//     clk_i, rst_i  : clock, async active-high reset
//     load_i        : a completed word is offered on this edge
//     load_data_i   : the completed word
//     ready_i       : consumer accepts data_o when valid_o is high
//     data_o        : held word (keeps last value after consume)
//     valid_o       : data_o holds an unconsumed word
//     overrun_o     : one-cycle pulse, offered word was dropped
module serial_deser_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overrun_o
);
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             w_free;

    // Free also when the held word leaves on this very edge, so a
    // simultaneous consume and complete replaces the word without overrun.
    assign w_free = !r_valid || ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= load_i && !w_free;
            if (load_i && w_free) begin
                r_data  <= load_data_i;
                r_valid <= 1'b1;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_o    = r_data;
    assign valid_o   = r_valid;
    assign overrun_o = r_overrun;
endmodule

// File: rtl/serial_deser.sv
// serial_deser
//   Collects a qualified serial bit stream into WIDTH-bit words and hands
//   each word to a one-word holding register with valid/ready output.
//   frame_i (qualified by bit_valid_i) forces a resync: the bit starts a new
//   word and any partial word is discarded with a frame_err_o pulse.
//   Parameters:
//     WIDTH     : word length, >= 2
//     MSB_FIRST : 1 = first bit lands in data_o[WIDTH-1], 0 = in data_o[0]
//   Ports:
//     clk_i, rst_i : clock, async active-high reset
//     bus          : serial_deser_if slave modport (bits in, word out)
module serial_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    serial_deser_if.slave  bus
);
    localparam int               CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_sh;
    logic [CNT_W-1:0] r_cnt;
    logic             r_frame_err;
    logic [WIDTH-1:0] w_sh_next;
    logic             w_complete;

    generate
        if (MSB_FIRST) begin : g_msb
            assign w_sh_next = {r_sh[WIDTH-2:0], bus.bit_i};
        end else begin : g_lsb
            assign w_sh_next = {bus.bit_i, r_sh[WIDTH-1:1]};
        end
    endgenerate

    // A framed bit is always bit 1 of a word, so it can never complete one
    // (WIDTH >= 2). Stale bits left in r_sh after a resync are shifted out
    // before the new word completes, so no explicit clear is needed.
    assign w_complete = bus.bit_valid_i && !bus.frame_i && (r_cnt == LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sh        <= '0;
            r_cnt       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (bus.bit_valid_i) begin
                r_sh <= w_sh_next;
                if (bus.frame_i) begin
                    r_cnt       <= CNT_W'(1);
                    r_frame_err <= (r_cnt != '0);
                end else if (w_complete) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.frame_err_o = r_frame_err;

    serial_deser_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (w_complete),
        .load_data_i (w_sh_next),
        .ready_i     (bus.ready_i),
        .data_o      (bus.data_o),
        .valid_o     (bus.valid_o),
        .overrun_o   (bus.overrun_o)
    );
endmodule

// File: tb/tb_serial_deser.sv
// tb_serial_deser
//   Two instances (MSB-first and LSB-first) share one stimulus stream and are
//   compared every cycle against a queue-based word model, plus a table and
//   hand-written sequences for the directed cases.
module tb_serial_deser;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_deser_if #(.WIDTH(W)) bus0 ();
    serial_deser_if #(.WIDTH(W)) bus1 ();

    serial_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk_i (clk), .rst_i (rst), .bus (bus0.slave));
    serial_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk_i (clk), .rst_i (rst), .bus (bus1.slave));

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bits of the word in progress, in arrival order.
    logic         q[$];
    logic         m_hv, m_ovr, m_ferr;
    logic [W-1:0] m_d0, m_d1;

    typedef struct {
        logic         bv, fr, b, rdy;
        logic         e_valid;
        logic [W-1:0] e_data;
        logic         e_ovr, e_ferr;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_hv = 0; m_ovr = 0; m_ferr = 0; m_d0 = '0; m_d1 = '0;
    endtask

    task automatic model_edge(input logic bv, fr, b, rdy);
        logic [W-1:0] w0, w1;
        logic got;
        got = 0; m_ovr = 0; m_ferr = 0; w0 = '0; w1 = '0;
        if (bv) begin
            if (fr) begin
                m_ferr = (q.size() != 0);
                q.delete();
            end
            q.push_back(b);
            if (q.size() == W) begin
                for (int i = 0; i < W; i++) begin
                    w0[W-1-i] = q[i];
                    w1[i]     = q[i];
                end
                got = 1;
                q.delete();
            end
        end
        if (got) begin
            if (!m_hv || rdy) begin
                m_hv = 1; m_d0 = w0; m_d1 = w1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_hv && rdy) begin
            m_hv = 0;
        end
    endtask

    task automatic cmp_model();
        chk("m_valid0", int'(bus0.valid_o), int'(m_hv));
        chk("m_data0",  int'(bus0.data_o), int'(m_d0));
        chk("m_ovr0",   int'(bus0.overrun_o), int'(m_ovr));
        chk("m_ferr0",  int'(bus0.frame_err_o), int'(m_ferr));
        chk("m_valid1", int'(bus1.valid_o), int'(m_hv));
        chk("m_data1",  int'(bus1.data_o), int'(m_d1));
        chk("m_ovr1",   int'(bus1.overrun_o), int'(m_ovr));
        chk("m_ferr1",  int'(bus1.frame_err_o), int'(m_ferr));
    endtask

    // Called at a negedge; drives inputs, takes one rising edge, returns at
    // the following negedge with outputs settled.
    task automatic step(input logic bv, fr, b, rdy);
        bus0.bit_valid_i = bv; bus0.frame_i = fr; bus0.bit_i = b; bus0.ready_i = rdy;
        bus1.bit_valid_i = bv; bus1.frame_i = fr; bus1.bit_i = b; bus1.ready_i = rdy;
        model_edge(bv, fr, b, rdy);
        @(posedge clk);
        @(negedge clk);
        cmp_model();
    endtask

    // Sends a word MSB-first on the wire; ready differs on the last bit.
    task automatic send_word(input logic [W-1:0] w, input logic fr,
                             input logic rdy_mid, input logic rdy_last);
        for (int i = 0; i < W; i++)
            step(1'b1, fr && (i == 0), w[W-1-i], (i == W-1) ? rdy_last : rdy_mid);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", int'(bus0.valid_o), 0);
        chk("rst_data",  int'(bus0.data_o), 0);
        chk("rst_ovr",   int'(bus0.overrun_o), 0);
        chk("rst_ferr",  int'(bus0.frame_err_o), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] pat1;
        logic [7:0] pat2;
        bus0.bit_i = 0; bus0.bit_valid_i = 0; bus0.frame_i = 0; bus0.ready_i = 0;
        bus1.bit_i = 0; bus1.bit_valid_i = 0; bus1.frame_i = 0; bus1.ready_i = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cmp_model();

        // 0xA5, MSB first, ready high: valid for exactly one cycle.
        a5 = 8'hA5;
        for (int i = 0; i < W; i++)
            tbl.push_back('{1'b1, i == 0, a5[W-1-i], 1'b1,
                            i == W-1, (i == W-1) ? 8'hA5 : 8'h00, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0});
        foreach (tbl[k]) begin
            step(tbl[k].bv, tbl[k].fr, tbl[k].b, tbl[k].rdy);
            chk("tbl_valid", int'(bus0.valid_o), int'(tbl[k].e_valid));
            chk("tbl_data",  int'(bus0.data_o), int'(tbl[k].e_data));
            chk("tbl_ovr",   int'(bus0.overrun_o), int'(tbl[k].e_ovr));
            chk("tbl_ferr",  int'(bus0.frame_err_o), int'(tbl[k].e_ferr));
        end

        // Backpressure and overrun.
        send_word(8'h3C, 1'b1, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b0, 1'b0);
        chk("bp_ovr",   int'(bus0.overrun_o), 1);
        chk("bp_valid", int'(bus0.valid_o), 1);
        chk("bp_data",  int'(bus0.data_o), 'h3C);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_ovr_pulse", int'(bus0.overrun_o), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_drain_valid", int'(bus0.valid_o), 0);
        chk("bp_drain_data",  int'(bus0.data_o), 'h3C);

        // Consume and complete on the same edge.
        send_word(8'h11, 1'b1, 1'b0, 1'b0);
        chk("sim_hold", int'(bus0.data_o), 'h11);
        send_word(8'h22, 1'b0, 1'b0, 1'b1);
        chk("sim_valid", int'(bus0.valid_o), 1);
        chk("sim_data",  int'(bus0.data_o), 'h22);
        chk("sim_ovr",   int'(bus0.overrun_o), 0);

        // Async reset while valid and an overrun pulse are high.
        send_word(8'h5A, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_ovr", int'(bus0.overrun_o), 1);
        async_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Resync mid-word.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("resync_ferr", int'(bus0.frame_err_o), 1);
        for (int i = 1; i < W; i++) step(1'b1, 1'b0, (i == W-1), 1'b1);
        chk("resync_ferr_pulse", int'(bus0.frame_err_o), 0);
        chk("resync_valid", int'(bus0.valid_o), 1);
        chk("resync_data",  int'(bus0.data_o), 'h81);

        // Gaps, LSB order; a frame with bit_valid low is ignored.
        pat1 = 8'b1000_0001;
        pat2 = 8'b0000_0001;
        for (int i = 0; i < W; i++) begin
            step(1'b1, 1'b0, pat1[i], 1'b1);
            step(1'b0, 1'b1, 1'b1, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("gap_data1", int'(bus1.data_o), 'h81);
        for (int i = 0; i < W; i++) begin
            step(1'b1, 1'b0, pat2[i], 1'b1);
            if (i == W-1) begin
                chk("gap_valid1", int'(bus1.valid_o), 1);
                chk("gap_data1b", int'(bus1.data_o), 'h01);
                chk("gap_data0b", int'(bus0.data_o), 'h80);
            end
            step(1'b0, 1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0,
                 1'($urandom), $urandom_range(0, 1) == 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_deser.md
Name: serial_deser

Overview:
Downstream consumer of the single-bit registered delay-line stage. Collects a serial bit stream (one bit per qualified clock) into WIDTH-bit words. Presents each completed word on a valid/ready output with a one-word holding register. Flags overrun (word lost under backpressure) and framing errors (resync mid-word).

Parameters:
WIDTH, 8, word length in bits; legal range is WIDTH >= 2.
MSB_FIRST, 1, 1 = first received bit lands in data_o[WIDTH-1]; 0 = first bit lands in data_o[0].

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  asynchronous, active-high reset.
bit_i  in  1  serial data bit.
bit_valid_i  in  1  bit_i is sampled on this edge only when this is high.
frame_i  in  1  qualified by bit_valid_i; marks bit_i as the first bit of a new word.
data_o  out  WIDTH  assembled word; stable while valid_o=1.
valid_o  out  1  data_o holds an unconsumed word.
ready_i  in  1  consumer accepts data_o on any edge where valid_o && ready_i.
overrun_o  out  1  one-cycle pulse: a completed word was dropped.
frame_err_o  out  1  one-cycle pulse: frame_i arrived while a partial word was in progress.

Behaviour:
- Reset (async assert, released synchronously by the environment):
  - shift register cleared; bit counter cnt = 0.
  - data_o = 0, valid_o = 0, overrun_o = 0, frame_err_o = 0.
  - Reset mid-word discards the partial word; a held word is discarded too.
- Counter width is $clog2(WIDTH+1). cnt counts bits of the current word, 0..WIDTH-1.
- Edge with bit_valid_i = 0: shift register and cnt hold. The pulses overrun_o and frame_err_o return to 0.
- Edge with bit_valid_i = 1 and frame_i = 1:
  - The bit becomes bit 1 of a new word; cnt becomes 1.
  - If the old cnt != 0, frame_err_o = 1 for one cycle and the partial word is discarded.
- Edge with bit_valid_i = 1 and frame_i = 0: shift the bit in; cnt increments.
- No frame_i is needed after reset: counting starts from cnt = 0.
- Shift direction:
  - MSB_FIRST = 1: sh <= {sh[WIDTH-2:0], bit_i}.
  - MSB_FIRST = 0: sh <= {bit_i, sh[WIDTH-1:1]}.
- Word complete: the bit sampled is the WIDTH-th bit (cnt == WIDTH-1 before the edge, or WIDTH-th counted after a frame). cnt returns to 0.
  - If the holding register is free (valid_o = 0, or valid_o && ready_i on the same edge): data_o gets the completed word and valid_o = 1.
  - Otherwise: the new word is dropped, data_o/valid_o are unchanged, and overrun_o = 1 for one cycle.
- Latency: valid_o rises on the edge that samples the last bit, so it is visible in the following cycle.
- Throughput: one word per WIDTH qualified bits.
- Consume without a new word on the same edge: valid_o && ready_i clears valid_o. data_o keeps its last value.
- Simultaneous consume and complete: valid_o stays 1, data_o is replaced with the new word, no overrun.
- data_o and valid_o must not change while valid_o = 1 and ready_i = 0, except on reset.
- frame_i with bit_valid_i = 0 is ignored.
- frame_i on a word's WIDTH-th bit position: it starts a new word (cnt = 1), and that edge does not complete a word.

Decomposition:
- No shared package needed. The only constant is the localparam CNT_W = $clog2(WIDTH+1).
- One natural sub-module, serial_deser_hold: the output holding register. It contains the valid/ready logic, the load/consume arbitration and overrun generation.
- The top level keeps the shift register, the counter and framing.

Test Plan:
1. Reset: assert rst_i asynchronously between edges while valid_o = 1 -> data_o = 0, valid_o = 0 and pulses 0 immediately, without waiting for an edge.
2. WIDTH = 8, MSB_FIRST = 1, ready_i = 1: send bits of 0xA5 on consecutive edges, frame_i with the first bit -> valid_o = 1 for exactly one cycle after the 8th edge, data_o = 0xA5, no pulses.
3. Backpressure: ready_i = 0, send 0x3C then 0xC3 -> data_o = 0x3C held with valid_o = 1; overrun_o pulses once after the 16th bit; then ready_i = 1 -> valid_o drops and data_o stays 0x3C.
4. Simultaneous: hold 0x11 with ready_i = 0; raise ready_i = 1 exactly on the edge the 8th bit of 0x22 is sampled -> valid_o stays 1, data_o = 0x22, overrun_o = 0.
5. Resync: send 3 bits, then frame_i with the first bit of 0x81 -> frame_err_o one-cycle pulse on that edge; data_o = 0x81 after 8 more bits counted from the frame.
6. Gaps and LSB order: MSB_FIRST = 0, bit_valid_i high every third cycle, bits 1,0,0,0,0,0,0,1 -> data_o = 0x81; with bits 1,0,0,0,0,0,0,0 -> data_o = 0x01; idle cycles never advance cnt.
